// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serial pattern generator and its matching sequence detector.
package seq_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } gen_state_e;

  // Canonical test sequence shared by generator and detector benches.
  localparam logic [3:0] DEFAULT_PAT = 4'b1011;

endpackage

// File: rtl/serial_pattern_generator.sv
// Serializes a latched pattern MSB first, optionally repeated with idle gaps; first bit one cycle after start.
// No backpressure: once accepted the transfer runs to completion unless aborted or reset.
module serial_pattern_generator
  import seq_fsm_pkg::*;
#(
  parameter int PAT_W    = 4,
  parameter int LEN_W    = 3,
  parameter int REP_W    = 4,
  parameter int GAP_CYC  = 0,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] repeat_n,
  input  logic             abort,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);

  gen_state_e       r_state, w_state_nxt;
  logic [PAT_W-1:0] r_shreg, w_shreg_nxt;
  logic [PAT_W-1:0] r_pat, w_pat_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [LEN_W-1:0] w_len_eff;
  logic [PAT_W-1:0] w_pat_aligned;

  // Out-of-range lengths (0 or above PAT_W) mean a full-width frame.
  assign w_len_eff     = (len == '0 || len > FULL_LEN) ? FULL_LEN : len;
  assign w_pat_aligned = pattern << (FULL_LEN - w_len_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_pat     <= '0;
      r_len     <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_pat     <= w_pat_nxt;
      r_len     <= w_len_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_pat_nxt     = r_pat;
    w_len_nxt     = r_len;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rep_cnt_nxt = r_rep_cnt;
    w_gap_cnt_nxt = r_gap_cnt;

    unique case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_pat_nxt     = w_pat_aligned;
          w_len_nxt     = w_len_eff;
          w_shreg_nxt   = w_pat_aligned;
          w_bit_cnt_nxt = w_len_eff - LEN_W'(1);
          w_rep_cnt_nxt = repeat_n;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_bit_cnt != '0) begin
          w_shreg_nxt   = r_shreg << 1;
          w_bit_cnt_nxt = r_bit_cnt - LEN_W'(1);
        end else if (r_rep_cnt == '0) begin
          w_state_nxt = DONE;
        end else begin
          // Next frame reloads here so a zero gap gives contiguous frames.
          w_rep_cnt_nxt = r_rep_cnt - REP_W'(1);
          w_shreg_nxt   = r_pat;
          w_bit_cnt_nxt = r_len - LEN_W'(1);
          if (GAP_CYC > 0) begin
            w_gap_cnt_nxt = GAP_LOAD;
            w_state_nxt   = GAP;
          end
        end
      end
      GAP: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_gap_cnt == '0) begin
          w_state_nxt = SHIFT;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign x     = (r_state == SHIFT) ? r_shreg[PAT_W-1] : IDLE_BIT;
  assign valid = (r_state == SHIFT);
  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench: two generator instances (gap 2 / idle 0, gap 0 / idle 1) share stimulus; a trace model feeds per-cycle scoreboards.
module tb_serial_pattern_generator;
  import seq_fsm_pkg::*;

  typedef logic [3:0] ev_t;      // {busy, valid, x, done}
  typedef ev_t evq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pattern = '0;
  logic [2:0] len = '0;
  logic [3:0] repeat_n = '0;

  logic x_a, valid_a, busy_a, done_a;
  logic x_b, valid_b, busy_b, done_b;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  evq_t qa, qb;

  serial_pattern_generator #(
    .PAT_W(4), .LEN_W(3), .REP_W(4), .GAP_CYC(2), .IDLE_BIT(1'b0)
  ) u_gen_a (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .repeat_n(repeat_n), .abort(abort),
    .x(x_a), .valid(valid_a), .busy(busy_a), .done(done_a)
  );

  serial_pattern_generator #(
    .PAT_W(4), .LEN_W(3), .REP_W(4), .GAP_CYC(0), .IDLE_BIT(1'b1)
  ) u_gen_b (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .repeat_n(repeat_n), .abort(abort),
    .x(x_b), .valid(valid_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Expected output of every cycle from acceptance: frames of bits, gaps, a done cycle, then one idle cycle.
  function automatic evq_t build_trace(input logic [3:0] pat, input logic [2:0] l,
                                       input logic [3:0] rep, input int gap, input logic ib);
    evq_t t;
    int   eff;
    eff = (l == 3'd0 || int'(l) > 4) ? 4 : int'(l);
    for (int f = 0; f <= int'(rep); f++) begin
      for (int b = eff - 1; b >= 0; b--) t.push_back({1'b1, 1'b1, pat[b], 1'b0});
      if (f < int'(rep))
        for (int g = 0; g < gap; g++) t.push_back({1'b1, 1'b0, ib, 1'b0});
    end
    t.push_back({1'b1, 1'b0, ib, 1'b1});
    t.push_back({1'b0, 1'b0, ib, 1'b0});
    return t;
  endfunction

  // Reference model: an empty queue means the generator is idle and may accept a start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || abort) begin
      qa.delete();
      qb.delete();
    end else if (start) begin
      if (qa.size() == 0) qa = build_trace(pattern, len, repeat_n, 2, 1'b0);
      if (qb.size() == 0) qb = build_trace(pattern, len, repeat_n, 0, 1'b1);
    end
  end

  task automatic check(input string name, input ev_t got, input ev_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d {busy,valid,x,done} got=%b want=%b", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ev_t ea, eb;
      ea = 4'b0000;
      eb = 4'b0010;
      if (qa.size() > 0) ea = qa.pop_front();
      if (qb.size() > 0) eb = qb.pop_front();
      check("gen_gap2", {busy_a, valid_a, x_a, done_a}, ea);
      check("gen_gap0", {busy_b, valid_b, x_b, done_b}, eb);
    end
  end

  task automatic send(input logic [3:0] p, input logic [2:0] l, input logic [3:0] r);
    @(negedge clk);
    pattern = p; len = l; repeat_n = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs after acceptance; the transfer must not see them.
    pattern = 4'($urandom); len = 3'($urandom); repeat_n = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_idle cycle=%0d queues still %0d/%0d want 0/0", cyc, qa.size(), qb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset held with start high: outputs must stay idle.
    start = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    send(DEFAULT_PAT, 3'd4, 4'd0);      wait_idle();
    send(4'b0101, 3'd3, 4'd0);          wait_idle();
    send(4'b1000, 3'd0, 4'd0);          wait_idle();
    send(4'b0110, 3'd7, 4'd0);          wait_idle();
    send(4'b0011, 3'd1, 4'd2);          wait_idle();
    send(DEFAULT_PAT, 3'd4, 4'd1);      wait_idle();

    // Abort in SHIFT.
    send(DEFAULT_PAT, 3'd4, 4'd0);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_idle();

    // Abort during a gap.
    send(DEFAULT_PAT, 3'd4, 4'd2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_idle();

    // Abort and start together in IDLE: start dropped.
    @(negedge clk); start = 1'b1; abort = 1'b1; pattern = 4'b1111;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);

    // Start mid-frame is ignored.
    send(DEFAULT_PAT, 3'd4, 4'd0);
    @(negedge clk); start = 1'b1; pattern = 4'b0110; len = 3'd2;
    @(negedge clk); start = 1'b0;
    wait_idle();

    // Reset mid-transfer, then a fresh frame.
    send(DEFAULT_PAT, 3'd4, 4'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    send(4'b1101, 3'd4, 4'd0);
    wait_idle();

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      pattern  = 4'($urandom);
      len      = 3'($urandom);
      repeat_n = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
